// File: rtl/pipe_pkg.sv
// Shared limits and helpers for the pipe_stage_chain slice.
// Holds payload/depth bounds, occupancy width and flush priority.
`timescale 1ns/1ps
package pipe_pkg;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 128;
  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 8;

  // A flush beats an output transfer in the same cycle.
  localparam bit FLUSH_WINS = 1'b1;

  // Two entries per stage at most, plus the empty state.
  function automatic int occ_w(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// One valid/ready register stage of the chain.
// SKID=1: main+skid entries, registered ready. SKID=0: plain reg.
`timescale 1ns/1ps
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  if (SKID != 0) begin : g_skid
    logic             main_v;
    logic             skid_v;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_d;
    logic             in_fire;
    logic             out_fire;

    assign in_ready  = !skid_v;
    assign out_valid = main_v;
    assign out_data  = main_d;
    assign in_fire   = in_valid & !skid_v;
    assign out_fire  = main_v & out_ready;

    // Main feeds downstream; skid catches the word in flight on a stall.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        main_v <= 1'b0;
        skid_v <= 1'b0;
        main_d <= '0;
        skid_d <= '0;
      end else if (flush && FLUSH_WINS) begin
        main_v <= 1'b0;
        skid_v <= 1'b0;
      end else if (skid_v) begin
        if (out_fire) begin
          main_d <= skid_d;
          skid_v <= 1'b0;
        end
      end else if (in_fire) begin
        if (!main_v || out_fire) begin
          main_v <= 1'b1;
          main_d <= in_data;
        end else begin
          skid_v <= 1'b1;
          skid_d <= in_data;
        end
      end else if (out_fire) begin
        main_v <= 1'b0;
      end
    end
  end else begin : g_plain
    logic             main_v;
    logic [WIDTH-1:0] main_d;

    assign in_ready  = !main_v | out_ready;
    assign out_valid = main_v;
    assign out_data  = main_d;

    // Load whenever the slot is free or being emptied this cycle.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        main_v <= 1'b0;
        main_d <= '0;
      end else if (flush && FLUSH_WINS) begin
        main_v <= 1'b0;
      end else if (in_ready) begin
        main_v <= in_valid;
        if (in_valid) main_d <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage valid/ready pipeline with flush and occupancy count.
// Optional perf counters: define PIPE_STAGE_CHAIN_PERF_EN.
`timescale 1ns/1ps
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int SKID  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [occ_w(DEPTH)-1:0]   occupancy
`ifdef PIPE_STAGE_CHAIN_PERF_EN
  ,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               bubble_cnt
`endif
);

  localparam int OW = occ_w(DEPTH);

  logic             alive_q;
  logic             vld [DEPTH+1];
  logic             rdy [DEPTH+1];
  logic [WIDTH-1:0] dat [DEPTH+1];
  logic [OW-1:0]    occ_q;
  logic             in_acc;
  logic             out_acc;

  // Hold off acceptance until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) alive_q <= 1'b0;
    else      alive_q <= 1'b1;
  end

  assign vld[0]     = in_valid & alive_q;
  assign dat[0]     = in_data;
  assign rdy[DEPTH] = out_ready;

  assign in_ready  = alive_q & !flush & rdy[0];
  assign out_valid = vld[DEPTH];
  assign out_data  = dat[DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_skid_stage #(
      .WIDTH (WIDTH),
      .SKID  (SKID)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (vld[i]),
      .in_ready  (rdy[i]),
      .in_data   (dat[i]),
      .out_valid (vld[i+1]),
      .out_ready (rdy[i+1]),
      .out_data  (dat[i+1])
    );
  end

  assign in_acc  = in_valid & in_ready;
  assign out_acc = out_valid & out_ready
                 & !(flush & FLUSH_WINS);

  // Track held words from boundary transfers; flush empties the chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= '0;
    end else begin
      unique case (1'b1)
        flush:              occ_q <= '0;
        in_acc & !out_acc:  occ_q <= occ_q + OW'(1);
        out_acc & !in_acc:  occ_q <= occ_q - OW'(1);
        default:            ;
      endcase
    end
  end

  assign occupancy = occ_q;

`ifdef PIPE_STAGE_CHAIN_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] bubble_q;

  // Saturating stall/bubble counters; flush leaves them alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (out_valid && !out_ready && stall_q != '1)
        stall_q <= stall_q + 32'd1;
      if (out_ready && !out_valid && bubble_q != '1)
        bubble_q <= bubble_q + 32'd1;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: DEPTH=4/SKID=1 and
// DEPTH=2/SKID=0 instances, checked against hand-derived values.
`timescale 1ns/1ps
module tb_pipe_stage_chain;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [31:0] a_in_data = '0;
  logic        a_flush = 1'b0;
  logic        a_out_valid;
  logic        a_out_ready = 1'b0;
  logic [31:0] a_out_data;
  logic [3:0]  a_occ;

  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [31:0] b_in_data = '0;
  logic        b_flush = 1'b0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic [31:0] b_out_data;
  logic [2:0]  b_occ;

`ifdef PIPE_STAGE_CHAIN_PERF_EN
  logic [31:0] a_stall;
  logic [31:0] a_bubble;
  logic [31:0] b_stall;
  logic [31:0] b_bubble;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stage_chain #(.WIDTH(32), .DEPTH(4), .SKID(1)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .flush     (a_flush),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .occupancy (a_occ)
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    ,
    .stall_cnt  (a_stall),
    .bubble_cnt (a_bubble)
`endif
  );

  pipe_stage_chain #(.WIDTH(32), .DEPTH(2), .SKID(0)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .flush     (b_flush),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .occupancy (b_occ)
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    ,
    .stall_cnt  (b_stall),
    .bubble_cnt (b_bubble)
`endif
  );

  task automatic test_reset();
    #2;
    n_tests++;
    if (a_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_in_ready: got %b exp 0", a_in_ready);
    end
    n_tests++;
    if (a_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_out_valid: got %b exp 0", a_out_valid);
    end
    n_tests++;
    if (a_out_data !== 32'h0) begin
      n_fail++; $display("FAIL rst_out_data: got %h exp 0", a_out_data);
    end
    n_tests++;
    if (a_occ !== 4'd0) begin
      n_fail++; $display("FAIL rst_occ: got %0d exp 0", a_occ);
    end
    n_tests++;
    if (b_in_ready !== 1'b0 || b_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_b: rdy %b vld %b exp 0 0", b_in_ready, b_out_valid);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (a_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rel_pre_edge: got %b exp 0", a_in_ready);
    end
    @(posedge clk); #1;
    n_tests++;
    if (a_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rel_edge: got %b exp 1", a_in_ready);
    end
  endtask

  task automatic test_stream();
    int idx = 0;
    int nout = 0;
    int acc0 = -1;
    int out0 = -1;
    int last = -1;
    int gaps = 0;
    a_out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      a_in_valid = (idx < 16);
      a_in_data  = 32'(idx + 1);
      @(negedge clk);
      if (a_in_valid && a_in_ready) begin
        if (acc0 < 0) acc0 = c;
        idx++;
      end
      if (a_out_valid && a_out_ready) begin
        n_tests++;
        if (a_out_data !== 32'(nout + 1)) begin
          n_fail++;
          $display("FAIL stream_data: got %h exp %h",
                   a_out_data, 32'(nout + 1));
        end
        if (out0 < 0) out0 = c;
        else if (c != last + 1) gaps++;
        last = c;
        nout++;
      end
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    n_tests++;
    if (out0 - acc0 != 4) begin
      n_fail++; $display("FAIL stream_latency: got %0d exp 4", out0 - acc0);
    end
    n_tests++;
    if (nout != 16) begin
      n_fail++; $display("FAIL stream_count: got %0d exp 16", nout);
    end
    n_tests++;
    if (gaps != 0) begin
      n_fail++; $display("FAIL stream_gaps: got %0d exp 0", gaps);
    end
  endtask

  task automatic test_fill();
    int k = 0;
    int unstable = 0;
    int nout = 0;
    a_out_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'h100 + 32'(k);
      @(negedge clk);
      if (a_in_valid && a_in_ready) k++;
      if (a_out_valid && a_out_data !== 32'h100) unstable++;
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (k != 8) begin
      n_fail++; $display("FAIL fill_accepts: got %0d exp 8", k);
    end
    n_tests++;
    if (a_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL fill_ready: got %b exp 0", a_in_ready);
    end
    n_tests++;
    if (a_occ !== 4'd8) begin
      n_fail++; $display("FAIL fill_occ: got %0d exp 8", a_occ);
    end
    n_tests++;
    if (a_out_valid !== 1'b1 || a_out_data !== 32'h100) begin
      n_fail++;
      $display("FAIL fill_head: vld %b data %h exp 1 100",
               a_out_valid, a_out_data);
    end
    n_tests++;
    if (unstable != 0) begin
      n_fail++; $display("FAIL fill_stable: got %0d exp 0", unstable);
    end
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (a_out_valid) begin
        n_tests++;
        if (a_out_data !== 32'h100 + 32'(nout)) begin
          n_fail++;
          $display("FAIL drain_data: got %h exp %h",
                   a_out_data, 32'h100 + 32'(nout));
        end
        nout++;
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (nout != 8 || a_occ !== 4'd0) begin
      n_fail++;
      $display("FAIL drain_end: cnt %0d occ %0d exp 8 0", nout, a_occ);
    end
  endtask

  task automatic test_flush();
    int k = 0;
    int seen = 0;
    a_out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'h200 + 32'(c);
      @(negedge clk);
      if (a_in_ready) k++;
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (a_occ !== 4'd5 || k != 5) begin
      n_fail++; $display("FAIL flush_pre: occ %0d acc %0d exp 5 5", a_occ, k);
    end
    @(posedge clk); #1;
    a_flush     = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data   = 32'hDEAD;
    a_out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_cycle: rdy %b vld %b exp 0 1",
               a_in_ready, a_out_valid);
    end
    @(posedge clk); #1;
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (a_occ !== 4'd0 || a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_after: occ %0d vld %b exp 0 0",
               a_occ, a_out_valid);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (a_out_valid || a_out_data === 32'hDEAD) seen++;
    end
    @(posedge clk); #1;
    n_tests++;
    if (seen != 0) begin
      n_fail++; $display("FAIL flush_leak: got %0d exp 0", seen);
    end
  endtask

  task automatic test_skid0();
    int idx = 0;
    int nout = 0;
    int bad_full = 0;
    int nfull = 0;
    for (int c = 0; c < 80; c++) begin
      b_out_ready = (c % 2 == 0);
      b_in_valid  = (idx < 16);
      b_in_data   = 32'hA0 + 32'(idx);
      @(negedge clk);
      if (b_in_valid && b_in_ready) idx++;
      if (b_out_valid && b_out_ready) begin
        n_tests++;
        if (b_out_data !== 32'hA0 + 32'(nout)) begin
          n_fail++;
          $display("FAIL skid0_data: got %h exp %h",
                   b_out_data, 32'hA0 + 32'(nout));
        end
        nout++;
      end
      if (b_occ == 3'd2) begin
        nfull++;
        if (b_in_ready !== b_out_ready) bad_full++;
      end
      @(posedge clk); #1;
    end
    b_in_valid  = 1'b0;
    b_out_ready = 1'b0;
    n_tests++;
    if (nout != 16) begin
      n_fail++; $display("FAIL skid0_count: got %0d exp 16", nout);
    end
    n_tests++;
    if (nfull == 0 || bad_full != 0) begin
      n_fail++;
      $display("FAIL skid0_full_ready: full %0d bad %0d exp >0 0",
               nfull, bad_full);
    end
  endtask

  task automatic test_reset_mid();
    a_out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'h400 + 32'(c);
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if (a_out_valid !== 1'b0 || a_out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_rst_out: vld %b data %h exp 0 0",
               a_out_valid, a_out_data);
    end
    n_tests++;
    if (a_occ !== 4'd0 || a_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_occ: occ %0d rdy %b exp 0 0",
               a_occ, a_in_ready);
    end
    rst = 1'b1;
    a_in_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (a_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_rst_release: got %b exp 1", a_in_ready);
    end
  endtask

`ifdef PIPE_STAGE_CHAIN_PERF_EN
  task automatic test_perf();
    bit hit = 1'b0;
    a_out_ready = 1'b0;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b1;
    a_in_data  = 32'h55;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      @(negedge clk);
      if (a_out_valid) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    n_tests++;
    if (!hit) begin
      n_fail++; $display("FAIL perf_wait: got timeout exp out_valid");
    end
    repeat (10) @(posedge clk);
    #1;
    a_out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    a_out_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (a_stall !== 32'd10) begin
      n_fail++; $display("FAIL perf_stall: got %0d exp 10", a_stall);
    end
    n_tests++;
    if (a_bubble !== 32'd3) begin
      n_fail++; $display("FAIL perf_bubble: got %0d exp 3", a_bubble);
    end
    @(posedge clk); #1;
    a_in_valid = 1'b1;
    a_in_data  = 32'h66;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      @(negedge clk);
      if (a_out_valid) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    dut_a.stall_q = 32'hFFFF_FFFE;
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if (!hit || a_stall !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL perf_sat: hit %b got %h exp ffffffff", hit, a_stall);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_flush();
    test_skid0();
    test_reset_mid();
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
- REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (1..128).
- REQ-002 SHALL have parameter DEPTH, default 4, number of register stages (1..8).
- REQ-003 SHALL have parameter SKID, default 1: 1 gives each stage a skid register (registered ready); 0 gives a plain register (combinational ready chain).
- REQ-004 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
- REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
- REQ-006 SHALL have port in_valid, input, 1, upstream word present.
- REQ-007 SHALL have port in_ready, output, 1, chain accepts a word this cycle.
- REQ-008 SHALL have port in_data, input, WIDTH, upstream payload.
- REQ-009 SHALL have port flush, input, 1, discards all held words (branch/jump redirect).
- REQ-010 SHALL have port out_valid, output, 1, word at chain tail.
- REQ-011 SHALL have port out_ready, input, 1, downstream accepts.
- REQ-012 SHALL have port out_data, output, WIDTH, tail payload.
- REQ-013 SHALL have port occupancy, output, clog2(2*DEPTH+1), count of held valid words.

Function
- REQ-014 SHALL transfer a word at each boundary only when valid and ready are both high in the same cycle.
- REQ-015 SHALL give DEPTH cycles of latency from input acceptance to out_valid, with the chain empty and out_ready high.
- REQ-016 SHALL sustain one word per cycle when out_ready stays high, for both SKID values.
- REQ-017 SHALL, with SKID=0, drive stage i ready = !valid_i | ready_(i+1).
- REQ-018 SHALL, with SKID=1, take each stage's ready only from its own registers, with no combinational path from out_ready to in_ready.
- REQ-019 SHALL, with SKID=1, make each stage two entries deep: main plus skid. The skid entry fills only when the main entry is held and downstream deasserts ready. Maximum occupancy is 2*DEPTH.
- REQ-020 SHALL preserve word order, with no loss or duplication, under any out_ready pattern.
- REQ-021 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
- REQ-022 SHALL, when flush is high, clear every valid bit at the next edge and force in_ready low during that cycle.
- REQ-023 SHALL discard any word offered during a flush cycle.
- REQ-024 SHALL give flush priority over a simultaneous output transfer. out_valid is still shown during the flush cycle, but the transfer is not counted.
- REQ-025 SHALL keep occupancy exact each cycle: +1 on input accept, -1 on output accept, unchanged when both or neither occur, 0 after flush.

Reset
- REQ-026 SHALL, while rst=0, asynchronously clear all valid bits and data registers.
- REQ-027 SHALL give these reset values: in_ready=0, out_valid=0, out_data=0, occupancy=0, and the performance counters (REQ-031) =0.
- REQ-028 SHALL raise in_ready on the first clk edge after rst deasserts.
- REQ-029 SHALL leave no partial word visible after a reset asserted mid-transfer.

Configuration
- REQ-030 SHALL use macro PIPE_STAGE_CHAIN_PERF_EN to select the performance-counter feature.
- REQ-031 SHALL, with the macro defined, add output stall_cnt[31:0], counting cycles with out_valid & !out_ready.
- REQ-032 SHALL, with the macro defined, add output bubble_cnt[31:0], counting cycles with out_ready & !out_valid.
- REQ-033 SHALL saturate both counters at 32'hFFFFFFFF and not clear them on flush.
- REQ-034 SHALL, without the macro, omit both ports and all counter logic.

Structure
- REQ-035 SHALL place the WIDTH/DEPTH limits, the occupancy-width function and the flush-priority constant in the shared package pipe_pkg.
- REQ-036 SHALL implement one stage as sub-module pipe_skid_stage (parameters WIDTH, SKID), instantiated DEPTH times by generate.

Verification
- REQ-037 SHALL cover: DEPTH=4, SKID=1, out_ready=1, feed 0x1..0x10 on consecutive cycles -> first out_valid 4 cycles after the first accept, 16 words in order, one per cycle.
- REQ-038 SHALL cover: DEPTH=4, SKID=1, out_ready=0, in_valid held high -> in_ready drops after 8 accepts, occupancy=8, out_data = first word and stable.
- REQ-039 SHALL cover: DEPTH=2, SKID=0, out_ready toggling 1010..., feed 0xA0..0xAF -> output order is 0xA0..0xAF, no gaps in data, and in_ready equals out_ready whenever the chain is full.
- REQ-040 SHALL cover: occupancy=5, assert flush for 1 cycle while in_valid=1 with 0xDEAD -> next cycle occupancy=0, out_valid=0, and 0xDEAD never appears.
- REQ-041 SHALL cover: rst pulled low for 1 ns mid-stream -> out_valid, out_data and occupancy are 0 immediately, and in_ready=1 one edge after release.
- REQ-042 SHALL cover, with PIPE_STAGE_CHAIN_PERF_EN: 10 stall cycles, then 3 empty cycles with out_ready=1 -> stall_cnt=10, bubble_cnt=3. Preloading a counter to 32'hFFFFFFFE and running 5 stall cycles -> it holds at 32'hFFFFFFFF.
